// File: rtl/ir_score_engine.sv
// ir_score_engine: N-channel IR hit scorer.
// Each raw sensor is synchronised (2 FF) and debounced. A rising debounced
// level on an unlocked channel while the game is running scores that
// channel's weight. A lockout then blocks the channel (or all channels, in
// shared mode) for LOCKOUT_CYCLES clocks. The score saturates at MAX_SCORE,
// and reaching it moves the game to DONE.
//
// Optional feature macro: LOCKOUT_EXTEND_EN. When it is defined, an edge on
// a locked channel restarts that channel's lockout counter (the shared one
// in global mode). No points are scored for that edge.
//
// Ports:
//   clk_100MHz   system clock
//   reset_n      asynchronous active-low reset
//   start        pulse, IDLE -> RUN with score cleared
//   clear        pulse, any state -> IDLE, clears score and lockouts
//   ir_sensors   raw asynchronous sensor levels, active-high
//   score_out    current binary score
//   bcd_ones     score mod 10, one cycle behind score_out
//   bcd_tens     score / 10, one cycle behind score_out
//   hit_pulse    one-cycle pulse when a hit is scored
//   hit_mask     channels scored in that cycle
//   locked       per-channel lockout state
//   state_out    00 IDLE, 01 RUN, 10 DONE
//   done         high while in DONE
module ir_score_engine #(
  parameter int unsigned              N_SENSORS        = 3,
  parameter int unsigned              SCORE_W          = 7,
  parameter int unsigned              MAX_SCORE        = 50,
  parameter logic [4*N_SENSORS-1:0]   POINTS           = {4'd1, 4'd1, 4'd1},
  parameter int unsigned              LOCKOUT_CYCLES   = 500_000_000,
  parameter int unsigned              DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned              PER_CHANNEL_LOCK = 0
) (
  input  logic                 clk_100MHz,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [N_SENSORS-1:0] ir_sensors,
  output logic [SCORE_W-1:0]   score_out,
  output logic [3:0]           bcd_ones,
  output logic [3:0]           bcd_tens,
  output logic                 hit_pulse,
  output logic [N_SENSORS-1:0] hit_mask,
  output logic [N_SENSORS-1:0] locked,
  output logic [1:0]           state_out,
  output logic                 done
);

  localparam int unsigned EXT_W = SCORE_W + 4;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LK_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Input conditioning state
  logic [N_SENSORS-1:0] sync1_q, sync1_d;
  logic [N_SENSORS-1:0] sync2_q, sync2_d;
  logic [N_SENSORS-1:0] deb_q, deb_d;
  logic [N_SENSORS-1:0] deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]      db_cnt_q [N_SENSORS];
  logic [DB_W-1:0]      db_cnt_d [N_SENSORS];

  // Lockout state; in shared mode every channel's copy moves in lockstep
  logic [N_SENSORS-1:0] lock_q, lock_d;
  logic [LK_W-1:0]      lk_cnt_q [N_SENSORS];
  logic [LK_W-1:0]      lk_cnt_d [N_SENSORS];

  // Game state and outputs
  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic [N_SENSORS-1:0] hit_mask_q, hit_mask_d;
  logic [3:0]           ones_q, ones_d;
  logic [3:0]           tens_q, tens_d;
  logic                 done_q, done_d;

  // Combinational helpers
  logic [N_SENSORS-1:0] rise_c;
  logic                 run_c;
  logic [N_SENSORS-1:0] elig_c;
  logic [N_SENSORS-1:0] lk_start_c;
  logic [EXT_W-1:0]     sum_c;
  logic [EXT_W-1:0]     score_ext_c;
  logic [SCORE_W-1:0]   capped_c;
  logic [EXT_W-1:0]     bcd_src_c;
`ifdef LOCKOUT_EXTEND_EN
  logic [N_SENSORS-1:0] blocked_c;
  logic [N_SENSORS-1:0] lk_ext_c;
`endif

  // Synchroniser and debounce: a level change needs DEBOUNCE_CYCLES
  // consecutive mismatching cycles, and any match restarts the count.
  always_comb begin
    sync1_d    = ir_sensors;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    db_cnt_d   = db_cnt_q;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Eligibility and weighted sum. clear suppresses any hit in its own cycle.
  always_comb begin
    rise_c = deb_q & ~deb_prev_q;
    run_c  = (state_q == ST_RUN) && !clear;
    elig_c = rise_c & ~lock_q & {N_SENSORS{run_c}};
    sum_c  = '0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (elig_c[i]) begin
        sum_c = sum_c + EXT_W'(POINTS[4*i +: 4]);
      end
    end
    score_ext_c = EXT_W'(score_q) + sum_c;
    capped_c    = (score_ext_c >= MAX_EXT) ? SCORE_W'(MAX_SCORE) : SCORE_W'(score_ext_c);
  end

  // Per-channel start/restart requests, fanned out to all copies in shared mode
  always_comb begin
    lk_start_c = '0;
`ifdef LOCKOUT_EXTEND_EN
    blocked_c  = rise_c & lock_q & {N_SENSORS{run_c}};
    lk_ext_c   = '0;
`endif
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (PER_CHANNEL_LOCK != 0) begin
        lk_start_c[i] = elig_c[i];
`ifdef LOCKOUT_EXTEND_EN
        lk_ext_c[i]   = blocked_c[i];
`endif
      end else begin
        lk_start_c[i] = |elig_c;
`ifdef LOCKOUT_EXTEND_EN
        lk_ext_c[i]   = |blocked_c;
`endif
      end
    end
  end

  // Lockout counters: locked for LOCKOUT_CYCLES cycles after the hit edge
  always_comb begin
    lock_d   = lock_q;
    lk_cnt_d = lk_cnt_q;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (clear) begin
        lock_d[i]   = 1'b0;
        lk_cnt_d[i] = '0;
      end else if (lk_start_c[i]) begin
        lock_d[i]   = 1'b1;
        lk_cnt_d[i] = '0;
`ifdef LOCKOUT_EXTEND_EN
      end else if (lk_ext_c[i]) begin
        lk_cnt_d[i] = '0;
`endif
      end else if (lock_q[i]) begin
        if (lk_cnt_q[i] == LK_LAST) begin
          lock_d[i]   = 1'b0;
          lk_cnt_d[i] = '0;
        end else begin
          lk_cnt_d[i] = lk_cnt_q[i] + LK_W'(1);
        end
      end
    end
  end

  // Game FSM with score update; clear has priority over start and hits
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    hit_mask_d = '0;
    if (clear) begin
      state_d = ST_IDLE;
      score_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            score_d = '0;
          end
        end
        ST_RUN: begin
          if (|elig_c) begin
            hit_d      = 1'b1;
            hit_mask_d = elig_c;
            score_d    = capped_c;
            if (score_ext_c >= MAX_EXT) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          score_d = '0;
        end
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  // BCD digits follow the registered score by one cycle
  always_comb begin
    bcd_src_c = EXT_W'(score_q);
    ones_d    = 4'(bcd_src_c % EXT_W'(10));
    tens_d    = 4'(bcd_src_c / EXT_W'(10));
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      lock_q     <= '0;
      for (int unsigned i = 0; i < N_SENSORS; i++) begin
        db_cnt_q[i] <= '0;
        lk_cnt_q[i] <= '0;
      end
      state_q    <= ST_IDLE;
      score_q    <= '0;
      hit_q      <= 1'b0;
      hit_mask_q <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      lock_q     <= lock_d;
      for (int unsigned i = 0; i < N_SENSORS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        lk_cnt_q[i] <= lk_cnt_d[i];
      end
      state_q    <= state_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      hit_mask_q <= hit_mask_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      done_q     <= done_d;
    end
  end

  assign score_out = score_q;
  assign bcd_ones  = ones_q;
  assign bcd_tens  = tens_q;
  assign hit_pulse = hit_q;
  assign hit_mask  = hit_mask_q;
  assign locked    = lock_q;
  assign state_out = state_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ir_score_engine.sv
// Directed bench for ir_score_engine: one shared-lockout instance (a) and
// one per-channel-lockout instance (b). Both use DEBOUNCE=4, LOCKOUT=20,
// MAX=10 and POINTS={3,2,1}. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
module tb_ir_score_engine;

  logic       clk;
  logic       rst_n;
  logic       start_a, clear_a, start_b, clear_b;
  logic [2:0] ir_a, ir_b;

  logic [6:0] score_a, score_b;
  logic [3:0] ones_a, tens_a, ones_b, tens_b;
  logic       hit_a, hit_b, done_a, done_b;
  logic [2:0] mask_a, mask_b, locked_a, locked_b;
  logic [1:0] state_a, state_b;

  int total;
  int bad;

`ifdef LOCKOUT_EXTEND_EN
  localparam logic [2:0] EXP_LOCK_MID = 3'b111;
`else
  localparam logic [2:0] EXP_LOCK_MID = 3'b000;
`endif

  ir_score_engine #(
    .N_SENSORS(3), .SCORE_W(7), .MAX_SCORE(10), .POINTS({4'd3, 4'd2, 4'd1}),
    .LOCKOUT_CYCLES(20), .DEBOUNCE_CYCLES(4), .PER_CHANNEL_LOCK(0)
  ) dut_a (
    .clk_100MHz(clk), .reset_n(rst_n), .start(start_a), .clear(clear_a),
    .ir_sensors(ir_a), .score_out(score_a), .bcd_ones(ones_a), .bcd_tens(tens_a),
    .hit_pulse(hit_a), .hit_mask(mask_a), .locked(locked_a),
    .state_out(state_a), .done(done_a)
  );

  ir_score_engine #(
    .N_SENSORS(3), .SCORE_W(7), .MAX_SCORE(10), .POINTS({4'd3, 4'd2, 4'd1}),
    .LOCKOUT_CYCLES(20), .DEBOUNCE_CYCLES(4), .PER_CHANNEL_LOCK(1)
  ) dut_b (
    .clk_100MHz(clk), .reset_n(rst_n), .start(start_b), .clear(clear_b),
    .ir_sensors(ir_b), .score_out(score_b), .bcd_ones(ones_b), .bcd_tens(tens_b),
    .hit_pulse(hit_b), .hit_mask(mask_b), .locked(locked_b),
    .state_out(state_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    total++; if (score_a !== 7'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score_a); end
    total++; if (state_a !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state_a); end
    total++; if (done_a !== 1'b0 || hit_a !== 1'b0) begin bad++; $display("FAIL reset_done_hit got=%b%b exp=00", done_a, hit_a); end
    total++; if (locked_a !== 3'b000 || mask_a !== 3'b000) begin bad++; $display("FAIL reset_lock_mask got=%b/%b exp=000/000", locked_a, mask_a); end
    total++; if (ones_a !== 4'd0 || tens_a !== 4'd0) begin bad++; $display("FAIL reset_bcd got=%0d%0d exp=00", tens_a, ones_a); end
    total++; if (score_b !== 7'd0 || state_b !== 2'b00) begin bad++; $display("FAIL reset_b got=%0d/%b exp=0/00", score_b, state_b); end
  endtask

  task automatic test_single_hit;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    total++; if (state_a !== 2'b01) begin bad++; $display("FAIL start_run got=%b exp=01", state_a); end
    ir_a = 3'b001;
    tick(1);            // edge that first samples the high level
    tick(5);
    total++; if (score_a !== 7'd0 || hit_a !== 1'b0) begin bad++; $display("FAIL latency_early got=%0d/%b exp=0/0", score_a, hit_a); end
    tick(1);            // sixth edge after first sample
    total++; if (score_a !== 7'd1) begin bad++; $display("FAIL latency_score got=%0d exp=1", score_a); end
    total++; if (hit_a !== 1'b1 || mask_a !== 3'b001) begin bad++; $display("FAIL hit_mask_s0 got=%b/%b exp=1/001", hit_a, mask_a); end
    total++; if (locked_a !== 3'b111) begin bad++; $display("FAIL lock_start got=%b exp=111", locked_a); end
    ir_a = 3'b000;
    tick(1);
    total++; if (hit_a !== 1'b0) begin bad++; $display("FAIL hit_one_cycle got=%b exp=0", hit_a); end
    total++; if (ones_a !== 4'd1 || tens_a !== 4'd0) begin bad++; $display("FAIL bcd_one got=%0d%0d exp=01", tens_a, ones_a); end
    tick(18);
    total++; if (locked_a !== 3'b111) begin bad++; $display("FAIL lock_last_cycle got=%b exp=111", locked_a); end
    tick(1);
    total++; if (locked_a !== 3'b000) begin bad++; $display("FAIL lock_release got=%b exp=000", locked_a); end
  endtask

  task automatic test_glitch;
    int hits;
    logic [2:0] m;
    ir_a = 3'b010; tick(3); ir_a = 3'b000;
    hits = 0;
    repeat (12) begin tick(1); if (hit_a === 1'b1) hits++; end
    total++; if (hits != 0 || score_a !== 7'd1) begin bad++; $display("FAIL glitch3 got hits=%0d score=%0d exp 0/1", hits, score_a); end
    ir_a = 3'b010; tick(4); ir_a = 3'b000;
    hits = 0; m = 3'b000;
    repeat (12) begin tick(1); if (hit_a === 1'b1) begin hits++; m = mask_a; end end
    total++; if (hits != 1 || m !== 3'b010) begin bad++; $display("FAIL glitch4_hit got hits=%0d mask=%b exp 1/010", hits, m); end
    total++; if (score_a !== 7'd3) begin bad++; $display("FAIL glitch4_score got=%0d exp=3", score_a); end
    tick(15);
    total++; if (locked_a !== 3'b000) begin bad++; $display("FAIL glitch4_unlock got=%b exp=000", locked_a); end
  endtask

  task automatic test_global_multi;
    int hits;
    ir_a = 3'b101; tick(7);
    total++; if (score_a !== 7'd7 || hit_a !== 1'b1) begin bad++; $display("FAIL multi_score got=%0d/%b exp=7/1", score_a, hit_a); end
    total++; if (mask_a !== 3'b101 || locked_a !== 3'b111) begin bad++; $display("FAIL multi_mask_lock got=%b/%b exp=101/111", mask_a, locked_a); end
    tick(2);
    ir_a = 3'b111;      // sensor1 edge lands mid-lockout
    hits = 0;
    repeat (18) begin tick(1); if (hit_a === 1'b1) hits++; end
    total++; if (hits != 0 || score_a !== 7'd7) begin bad++; $display("FAIL locked_drop got hits=%0d score=%0d exp 0/7", hits, score_a); end
    total++; if (locked_a !== EXP_LOCK_MID) begin bad++; $display("FAIL lock_after20 got=%b exp=%b", locked_a, EXP_LOCK_MID); end
    tick(8);
    total++; if (locked_a !== EXP_LOCK_MID) begin bad++; $display("FAIL lock_ext_end got=%b exp=%b", locked_a, EXP_LOCK_MID); end
    tick(1);
    total++; if (locked_a !== 3'b000) begin bad++; $display("FAIL lock_ext_release got=%b exp=000", locked_a); end
    ir_a = 3'b000; tick(8);
  endtask

  task automatic test_saturate;
    int hits;
    ir_a = 3'b010; tick(7);
    total++; if (score_a !== 7'd9) begin bad++; $display("FAIL pre_sat_score got=%0d exp=9", score_a); end
    ir_a = 3'b000; tick(1);
    total++; if (tens_a !== 4'd0 || ones_a !== 4'd9) begin bad++; $display("FAIL bcd_nine got=%0d%0d exp=09", tens_a, ones_a); end
    tick(25);
    ir_a = 3'b100; tick(7);
    total++; if (score_a !== 7'd10) begin bad++; $display("FAIL sat_score got=%0d exp=10", score_a); end
    total++; if (state_a !== 2'b10 || done_a !== 1'b1) begin bad++; $display("FAIL sat_done got=%b/%b exp=10/1", state_a, done_a); end
    total++; if (tens_a !== 4'd0 || ones_a !== 4'd9) begin bad++; $display("FAIL bcd_lag got=%0d%0d exp=09", tens_a, ones_a); end
    tick(1);
    total++; if (tens_a !== 4'd1 || ones_a !== 4'd0) begin bad++; $display("FAIL bcd_ten got=%0d%0d exp=10", tens_a, ones_a); end
    ir_a = 3'b000; tick(25);
    ir_a = 3'b001;
    hits = 0;
    repeat (10) begin tick(1); if (hit_a === 1'b1) hits++; end
    total++; if (hits != 0 || score_a !== 7'd10 || state_a !== 2'b10) begin bad++; $display("FAIL done_hold got hits=%0d score=%0d st=%b exp 0/10/10", hits, score_a, state_a); end
    ir_a = 3'b000; tick(8);
  endtask

  task automatic test_per_channel;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    ir_b = 3'b100; tick(5);
    ir_b = 3'b101; tick(2);
    total++; if (score_b !== 7'd3 || mask_b !== 3'b100 || hit_b !== 1'b1) begin bad++; $display("FAIL pc_hit2 got=%0d/%b/%b exp=3/100/1", score_b, mask_b, hit_b); end
    total++; if (locked_b !== 3'b100) begin bad++; $display("FAIL pc_lock2 got=%b exp=100", locked_b); end
    tick(5);
    total++; if (score_b !== 7'd4 || mask_b !== 3'b001) begin bad++; $display("FAIL pc_hit0 got=%0d/%b exp=4/001", score_b, mask_b); end
    total++; if (locked_b !== 3'b101) begin bad++; $display("FAIL pc_lock_both got=%b exp=101", locked_b); end
    tick(14);
    total++; if (locked_b !== 3'b101) begin bad++; $display("FAIL pc_lock2_last got=%b exp=101", locked_b); end
    tick(1);
    total++; if (locked_b !== 3'b001) begin bad++; $display("FAIL pc_unlock2 got=%b exp=001", locked_b); end
    tick(4);
    total++; if (locked_b !== 3'b001) begin bad++; $display("FAIL pc_lock0_last got=%b exp=001", locked_b); end
    tick(1);
    total++; if (locked_b !== 3'b000) begin bad++; $display("FAIL pc_unlock0 got=%b exp=000", locked_b); end
    ir_b = 3'b000;
  endtask

  task automatic test_reset_mid;
    clear_a = 1'b1; tick(1); clear_a = 1'b0;
    total++; if (state_a !== 2'b00 || score_a !== 7'd0 || done_a !== 1'b0) begin bad++; $display("FAIL clear_done got=%b/%0d/%b exp=00/0/0", state_a, score_a, done_a); end
    start_a = 1'b1; tick(1); start_a = 1'b0;
    ir_a = 3'b001; tick(7);
    total++; if (score_a !== 7'd1 || locked_a !== 3'b111) begin bad++; $display("FAIL pre_reset got=%0d/%b exp=1/111", score_a, locked_a); end
    ir_a = 3'b011; tick(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if (score_a !== 7'd0 || locked_a !== 3'b000 || state_a !== 2'b00) begin bad++; $display("FAIL async_reset got=%0d/%b/%b exp=0/000/00", score_a, locked_a, state_a); end
    total++; if (ones_a !== 4'd0 || hit_a !== 1'b0 || mask_a !== 3'b000 || done_a !== 1'b0) begin bad++; $display("FAIL async_reset_out got=%0d/%b/%b/%b exp=0/0/000/0", ones_a, hit_a, mask_a, done_a); end
    ir_a = 3'b000;
    @(posedge clk); #1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    start_a = 1'b1; clear_a = 1'b1; tick(1); start_a = 1'b0; clear_a = 1'b0;
    total++; if (state_a !== 2'b00) begin bad++; $display("FAIL clear_wins got=%b exp=00", state_a); end
    start_a = 1'b1; tick(1); start_a = 1'b0;
    total++; if (state_a !== 2'b01) begin bad++; $display("FAIL restart_run got=%b exp=01", state_a); end
    tick(10);
    total++; if (score_a !== 7'd0 || locked_a !== 3'b000) begin bad++; $display("FAIL no_pending_hit got=%0d/%b exp=0/000", score_a, locked_a); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0; clear_a = 1'b0; ir_a = 3'b000;
    start_b = 1'b0; clear_b = 1'b0; ir_b = 3'b000;
    tick(3);
    test_reset;
    rst_n = 1'b1;
    tick(2);
    test_single_hit;
    test_glitch;
    test_global_multi;
    test_saturate;
    test_per_channel;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_score_engine.md
Name: ir_score_engine

Overview:
Parametrised successor to the fixed 3-sensor IR score counter. It takes N raw IR sensor inputs and synchronises and debounces each one. Rising edges are converted into weighted score increments, with either global or per-channel lockout. A run/done game state machine saturates the score at a configurable target. The block sits between the board IR inputs and the display/game-control logic, and drives binary score plus two BCD digits.

Parameters:
N_SENSORS, 3, number of IR channels (1..8)
SCORE_W, 7, score register width
MAX_SCORE, 50, target score; saturation point and DONE trigger (must be < 2^SCORE_W and <= 99)
POINTS, {4'd1,4'd1,4'd1}, packed 4-bit weight per channel; channel i uses POINTS[4i+3:4i]
LOCKOUT_CYCLES, 500_000_000, lockout length in clocks (5 s at 100 MHz)
DEBOUNCE_CYCLES, 1_000_000, consecutive mismatch cycles before a debounced level changes
PER_CHANNEL_LOCK, 0, 0 = one shared lockout; 1 = independent lockout per channel

Ports:
clk_100MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: IDLE->RUN, clears score
clear  input  1  one-cycle pulse: any state->IDLE, clears score and lockouts
ir_sensors  input  N_SENSORS  raw sensor levels, asynchronous, active-high
score_out  output  SCORE_W  current score
bcd_ones  output  4  score mod 10
bcd_tens  output  4  score / 10
hit_pulse  output  1  one-cycle pulse when a hit is scored
hit_mask  output  N_SENSORS  channels scored this cycle (valid with hit_pulse)
locked  output  N_SENSORS  per-channel lockout active (all bits equal when PER_CHANNEL_LOCK=0)
state_out  output  2  00 IDLE, 01 RUN, 10 DONE
done  output  1  high in DONE

Behaviour:
- Reset (reset_n low, async): all outputs 0, state IDLE, all counters and synchronisers 0, debounced levels 0.
- Per channel: 2-FF synchroniser, then debounce. The debounced level takes the synced level on the DEBOUNCE_CYCLES-th consecutive cycle of mismatch. Any match resets the count.
- Edge = debounced level rising, registered against its previous value.
- Latency: score_out, hit_pulse and hit_mask update on clock edge DEBOUNCE_CYCLES+2, counted after the edge that first samples a clean high.
- Eligible channel: edge present, channel not locked, state RUN.
- Global mode: all eligible edges in the same cycle are scored together. Increment is the sum of their POINTS. The shared lockout starts once.
- Per-channel mode: each eligible channel is scored and starts its own lockout counter.
- Lockout: a counter runs from 0 to LOCKOUT_CYCLES-1. The channel unlocks on the following edge, i.e. it is locked for exactly LOCKOUT_CYCLES cycles starting the cycle after the hit. An edge on the unlock cycle itself is accepted.
- Edges on locked channels are dropped with no effect, except as described under Optional Feature.
- Arithmetic: the sum is computed in SCORE_W+4 bits. The new score is min(score + sum, MAX_SCORE). No wrap.
- FSM:
  - IDLE: edges ignored. start -> RUN with score 0.
  - RUN: a hit taking the score to MAX_SCORE -> DONE in the same edge as the score update.
  - DONE: edges ignored; score held.
  - clear from any state -> IDLE, score 0, all locks released.
  - clear and start in the same cycle: clear wins.
  - start in RUN or DONE: ignored.
- bcd_ones/bcd_tens: registered, updated one cycle after score_out.
- Reset asserted mid-lockout or mid-debounce: immediate full clear. No pending hit survives.

Optional Feature:
LOCKOUT_EXTEND_EN
- Defined: an edge arriving on a locked channel restarts that channel's lockout counter (the shared counter in global mode) from 0. No points are scored.
- Undefined: edges on locked channels are ignored and the counter runs undisturbed.

Test Plan:
All scenarios use N_SENSORS=3, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, MAX_SCORE=10, POINTS={3,2,1}.
1. Reset, then start, then clean high on sensor0 -> score_out=1 exactly 6 clocks after the first sample; hit_pulse=1 for one cycle; hit_mask=001; locked=111 for 20 cycles.
2. Glitch of 3 cycles on sensor1 -> no hit. Glitch of 4 cycles -> hit with +2.
3. Global mode: sensor0 and sensor2 rise on the same cycle -> score +4 and hit_mask=101. An edge on sensor1 during lockout -> no change. The same edge with LOCKOUT_EXTEND_EN -> lockout lasts 20 cycles from that edge.
4. PER_CHANNEL_LOCK=1: sensor2 hit, then sensor0 hit 5 cycles later -> both scored (+3, then +1); locked=101 afterwards; each clears 20 cycles after its own hit.
5. Score at 9, sensor2 hit -> score_out=10, state DONE, done=1, bcd_tens=1, bcd_ones=0 one cycle later. Further edges -> no change.
6. Assert reset_n low during lockout and mid-debounce -> all outputs 0 immediately. clear and start on the same cycle -> state IDLE.
